// File: rtl/sigdel_pkg.sv
// sigdel_pkg: constants shared by the sigma-delta CIC decimator.
//   CIC_ORDER     number of integrator/comb pairs (sinc2)
//   PCM_W         width of the decimated PCM output
//   DEC_LOG2_MIN  smallest supported log2 decimation ratio
//   DEC_LOG2_MAX  largest supported log2 decimation ratio
//   out_shift()   right shift that maps the full-precision CIC result
//                 (0..R**CIC_ORDER) onto PCM_W bits
package sigdel_pkg;

  localparam int CIC_ORDER    = 2;
  localparam int PCM_W        = 8;
  localparam int DEC_LOG2_MIN = 4;
  localparam int DEC_LOG2_MAX = 7;

  // Full-scale CIC output is 2**(CIC_ORDER*dec_log2); keep the top PCM_W
  // bits, leaving exactly full scale one count above the PCM range.
  function automatic int out_shift(input int dec_log2);
    return CIC_ORDER * dec_log2 - PCM_W;
  endfunction

endpackage

// File: rtl/sigdel_cic_integrator.sv
// sigdel_cic_integrator: one CIC integrator stage.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the accumulator
//   en     accumulate din on this edge when high, hold otherwise
//   din    ACC_W-bit addend
//   acc    ACC_W-bit running sum, wraps modulo 2**ACC_W
module sigdel_cic_integrator #(
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] acc
);

  // Wrap-around is intentional: the combs difference consecutive values,
  // so the modulo error cancels as long as ACC_W covers the output range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/sigdel_cic_decim.sv
// sigdel_cic_decim: 2nd-order CIC (sinc2) decimator for a 1-bit
// sigma-delta stream, R = 2**DEC_LOG2, DEC_LOG2 supported over
// sigdel_pkg::DEC_LOG2_MIN..DEC_LOG2_MAX.
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   en            accept bit_in on this edge
//   bit_in        bitstream sample (weight 0 or 1)
//   sample_out    scaled, saturated PCM sample, held between strobes
//   sample_valid  one-cycle strobe, 2 clocks after the block-closing accept
//   sample_sat    sample was clipped to full scale
//   warm          first valid sample after reset has been produced
module sigdel_cic_decim
  import sigdel_pkg::*;
#(
  parameter int DEC_LOG2 = 5,
  parameter int ACC_W    = 2 * DEC_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bit_in,
  output logic [PCM_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             sample_sat,
  output logic             warm
);

  localparam int         SHIFT       = out_shift(DEC_LOG2);
  localparam logic [1:0] WARM_BLOCKS = 2'(CIC_ORDER);

  logic [ACC_W-1:0]    int1;
  logic [ACC_W-1:0]    int2;
  logic [ACC_W-1:0]    int1_next;
  logic [ACC_W-1:0]    int2_d;
  logic [ACC_W-1:0]    c1;
  logic [ACC_W-1:0]    c1_d;
  logic [ACC_W-1:0]    c2;
  logic [ACC_W-1:0]    y_reg;
  logic [ACC_W-1:0]    y_shift;
  logic [DEC_LOG2-1:0] dec_cnt;
  logic [1:0]          warm_cnt;
  logic                block_close;
  logic                comb_go;
  logic                y_go;
  logic                sat_next;
  logic [PCM_W-1:0]    out_next;

  // The second integrator sums the first integrator's updated value so the
  // block-closing bit itself lands in the window (weight 1 at the newest
  // position), giving the exact triangular sum of the last 2R-1 bits.
  assign int1_next = int1 + {{(ACC_W-1){1'b0}}, bit_in};

  sigdel_cic_integrator #(.ACC_W(ACC_W)) u_int1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .din   ({{(ACC_W-1){1'b0}}, bit_in}),
    .acc   (int1)
  );

  sigdel_cic_integrator #(.ACC_W(ACC_W)) u_int2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .din   (int1_next),
    .acc   (int2)
  );

  assign block_close = en && (dec_cnt == '1);

  // Decimation counter wraps naturally at R.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (en) begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  assign c1 = int2 - int2_d;
  assign c2 = c1 - c1_d;

  // Comb stage, one clock after the closing accept. It runs on comb_go
  // rather than en, so the sample emerges on a fixed schedule even if the
  // bitstream pauses. int2 is sampled before this edge's update, i.e. the
  // value latched by the closing accept. The first blocks after reset only
  // prime the comb delay registers and are not published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_go  <= 1'b0;
      int2_d   <= '0;
      c1_d     <= '0;
      y_reg    <= '0;
      y_go     <= 1'b0;
      warm_cnt <= '0;
    end else begin
      comb_go <= block_close;
      y_go    <= 1'b0;
      if (comb_go) begin
        int2_d <= int2;
        c1_d   <= c1;
        y_reg  <= c2;
        if (warm_cnt == WARM_BLOCKS) begin
          y_go <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + 1'b1;
        end
      end
    end
  end

  // y never exceeds R**2, so after the shift only the single full-scale
  // value sets a bit at or above PCM_W.
  assign y_shift  = y_reg >> SHIFT;
  assign sat_next = |y_shift[ACC_W-1:PCM_W];
  assign out_next = sat_next ? '1 : y_shift[PCM_W-1:0];

  // Output register: sample and flag are held until the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out   <= '0;
      sample_sat   <= 1'b0;
      sample_valid <= 1'b0;
      warm         <= 1'b0;
    end else begin
      sample_valid <= y_go;
      if (y_go) begin
        sample_out <= out_next;
        sample_sat <= sat_next;
        warm       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sigdel_cic_decim.sv
// tb_sigdel_cic_decim: directed bench for sigdel_cic_decim. A DEC_LOG2=5
// instance carries most scenarios; a DEC_LOG2=4 instance shares the inputs
// and is used for the integrator wrap-around scenario.
module tb_sigdel_cic_decim;

  localparam int R5 = 32;
  localparam int R4 = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       bit_in = 1'b0;
  logic [7:0] out5, out4;
  logic       valid5, valid4, sat5, sat4, warm5, warm4;

  int vectors = 0;
  int miscompares = 0;

  // Reference timing state for the DEC_LOG2=5 instance: accepted bits in the
  // current block, closed blocks since reset, and a 3-deep pipe carrying
  // "this block is published" from the closing accept to the strobe.
  int   acc_cnt, blocks, accepted;
  bit   pa, pb, pc;
  bit   exp_warm;
  logic [8:0] exp_word;

  sigdel_cic_decim #(.DEC_LOG2(5)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .bit_in       (bit_in),
    .sample_out   (out5),
    .sample_valid (valid5),
    .sample_sat   (sat5),
    .warm         (warm5)
  );

  sigdel_cic_decim #(.DEC_LOG2(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .bit_in       (bit_in),
    .sample_out   (out4),
    .sample_valid (valid4),
    .sample_sat   (sat4),
    .warm         (warm4)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    acc_cnt  = 0;
    blocks   = 0;
    accepted = 0;
    pa = 0; pb = 0; pc = 0;
    exp_warm = 0;
  endtask

  // Called at a falling edge; drives one cycle and returns at the next
  // falling edge with the reference state advanced past the rising edge.
  task automatic step(input logic b, input logic e);
    bit close;
    en     = e;
    bit_in = b;
    @(posedge clk);
    close = e && (acc_cnt == R5 - 1);
    pc = pb;
    pb = pa;
    pa = close && (blocks >= 2);
    if (e) begin
      accepted++;
      if (close) begin
        acc_cnt = 0;
        blocks++;
      end else begin
        acc_cnt++;
      end
    end
    if (pc) exp_warm = 1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({warm5, sat5, valid5, out5, warm4, sat4, valid4, out4} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %b want all zero",
               {warm5, sat5, valid5, out5, warm4, sat4, valid4, out4});
    end
    @(negedge clk);
    vectors++;
    if ({warm5, sat5, valid5, out5} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %b want all zero", {warm5, sat5, valid5, out5});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    int nv = 0;
    apply_reset();
    exp_word = {1'b0, 8'd0};
    for (int i = 0; i < 5 * R5 + 2; i++) begin
      step(1'b0, i < 5 * R5);
      if (valid5 === 1'b1) nv++;
      vectors++;
      if (valid5 !== pc) begin
        miscompares++;
        $display("[TB] FAIL zero_valid bit %0d: got %b want %b", accepted, valid5, pc);
      end
      vectors++;
      if ({sat5, out5} !== exp_word) begin
        miscompares++;
        $display("[TB] FAIL zero_sample bit %0d: got %h want %h", accepted, {sat5, out5}, exp_word);
      end
    end
    vectors++;
    if (nv != 3) begin
      miscompares++;
      $display("[TB] FAIL zero_count: got %0d want 3", nv);
    end
  endtask

  task automatic test_all_ones();
    apply_reset();
    for (int i = 0; i < 5 * R5 + 2; i++) begin
      step(1'b1, i < 5 * R5);
      exp_word = exp_warm ? {1'b1, 8'd255} : 9'd0;
      vectors++;
      if (valid5 !== pc) begin
        miscompares++;
        $display("[TB] FAIL ones_valid bit %0d: got %b want %b", accepted, valid5, pc);
      end
      vectors++;
      if ({sat5, out5} !== exp_word || warm5 !== exp_warm) begin
        miscompares++;
        $display("[TB] FAIL ones_sample bit %0d: got %h/%b want %h/%b",
                 accepted, {sat5, out5}, warm5, exp_word, exp_warm);
      end
    end
  endtask

  // 1,0 weighs 512 of 1024 -> 128; 1,0,0,0 weighs 256 -> 64.
  task automatic test_patterns();
    logic [3:0] pat;
    int         plen;
    logic [7:0] want;
    for (int k = 0; k < 2; k++) begin
      pat  = (k == 0) ? 4'b0001 : 4'b0001;
      plen = (k == 0) ? 2 : 4;
      want = (k == 0) ? 8'd128 : 8'd64;
      apply_reset();
      for (int i = 0; i < 5 * R5 + 2; i++) begin
        step(pat[accepted % plen], i < 5 * R5);
        exp_word = exp_warm ? {1'b0, want} : 9'd0;
        vectors++;
        if (valid5 !== pc) begin
          miscompares++;
          $display("[TB] FAIL pat%0d_valid bit %0d: got %b want %b", plen, accepted, valid5, pc);
        end
        vectors++;
        if ({sat5, out5} !== exp_word || warm5 !== exp_warm) begin
          miscompares++;
          $display("[TB] FAIL pat%0d_sample bit %0d: got %h/%b want %h/%b",
                   plen, accepted, {sat5, out5}, warm5, exp_word, exp_warm);
        end
      end
    end
  endtask

  // 1,1,1,0 weighs 768 -> 192, with en active roughly 30% of cycles.
  task automatic test_random_en();
    logic [3:0] pat = 4'b0111;
    int         cyc = 0;
    apply_reset();
    while (blocks < 6 && cyc < 3000) begin
      step(pat[accepted % 4], $urandom_range(0, 99) < 30);
      cyc++;
      exp_word = exp_warm ? {1'b0, 8'd192} : 9'd0;
      vectors++;
      if (valid5 !== pc) begin
        miscompares++;
        $display("[TB] FAIL rnd_valid cyc %0d: got %b want %b", cyc, valid5, pc);
      end
      vectors++;
      if ({sat5, out5} !== exp_word || warm5 !== exp_warm) begin
        miscompares++;
        $display("[TB] FAIL rnd_sample cyc %0d: got %h/%b want %h/%b",
                 cyc, {sat5, out5}, warm5, exp_word, exp_warm);
      end
    end
    vectors++;
    if (blocks < 6) begin
      miscompares++;
      $display("[TB] FAIL rnd_budget: got %0d blocks want 6", blocks);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      vectors++;
      if (valid5 !== pc || {sat5, out5} !== {1'b0, 8'd192}) begin
        miscompares++;
        $display("[TB] FAIL rnd_flush: got %b/%h want %b/%h", valid5, {sat5, out5}, pc, 9'd192);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] pat = 4'b0001;
    int         nv = 0;
    int         cyc = 0;
    apply_reset();
    while (nv < 10 && cyc < 1000) begin
      step(pat[accepted % 2], 1'b1);
      cyc++;
      if (pc) nv++;
    end
    for (int i = 0; i < 10; i++) step(pat[accepted % 2], 1'b1);
    vectors++;
    if (nv < 10 || {warm5, sat5, out5} !== {1'b1, 1'b0, 8'd128}) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre: got %0d/%h want 10/%h", nv, {warm5, sat5, out5}, 10'h280);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({warm5, sat5, valid5, out5} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_clear: got %b want all zero", {warm5, sat5, valid5, out5});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pat = 4'b0001;
    for (int i = 0; i < 4 * R5 + 2; i++) begin
      step(pat[accepted % 4], i < 4 * R5);
      exp_word = exp_warm ? {1'b0, 8'd64} : 9'd0;
      vectors++;
      if (valid5 !== pc) begin
        miscompares++;
        $display("[TB] FAIL midrst_valid bit %0d: got %b want %b", accepted, valid5, pc);
      end
      vectors++;
      if ({sat5, out5} !== exp_word || warm5 !== exp_warm) begin
        miscompares++;
        $display("[TB] FAIL midrst_sample bit %0d: got %h/%b want %h/%b",
                 accepted, {sat5, out5}, warm5, exp_word, exp_warm);
      end
    end
  endtask

  // DEC_LOG2=4: ACC_W=9, so 600 ones wrap the integrators; every sample is
  // y=256 clipped. Blocks close at bits 16k-1; blocks 2..36 publish.
  task automatic test_wrap();
    int nv = 0;
    apply_reset();
    for (int i = 0; i < 600 + 2; i++) begin
      step(1'b1, i < 600);
      if (valid4 === 1'b1) begin
        nv++;
        vectors++;
        if ({sat4, out4} !== {1'b1, 8'd255}) begin
          miscompares++;
          $display("[TB] FAIL wrap_sample %0d: got %h want %h", nv, {sat4, out4}, 9'h1ff);
        end
      end
    end
    vectors++;
    if (nv != 600 / R4 - 2 || warm4 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_count: got %0d/%b want %0d/1", nv, warm4, 600 / R4 - 2);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_zero();
    test_all_ones();
    test_patterns();
    test_random_en();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
